mux_arb_nx1: RTL

- Parametrised M-input, N-bit selector with a registered output stage and valid/ready handshakes on every input and on the output.
- Successor to the combinational 4:1 datapath mux.
- Shares one downstream consumer among several requesters, e.g. the single memory port shared by instruction fetch and MEM-stage load/store.
- Selection is external, fixed-priority or round-robin, fixed at elaboration.

---
 rtl/mux_pkg.sv | 27 ++
 rtl/mux_arb_grant.sv | 59 +++++
 rtl/mux_arb_nx1.sv | 103 ++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the N-input arbitrating selector.
//   MUX_MODE_SEL  : grant follows the external sel input
//   MUX_MODE_PRIO : fixed priority, lowest valid index wins
//   MUX_MODE_RR   : round-robin starting from the rotating pointer
//   clog2()       : width of an index field able to address 'value' entries
// -----------------------------------------------------------------------------
package mux_pkg;

    localparam int MUX_MODE_SEL  = 0;
    localparam int MUX_MODE_PRIO = 1;
    localparam int MUX_MODE_RR   = 2;

    // Never returns less than 1 so a select field always has at least one bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/mux_arb_grant.sv
// -----------------------------------------------------------------------------
// mux_arb_grant
// Combinational grant logic for mux_arb_nx1.
// Ports:
//   in_valid  [M]      per-input request valid
//   sel       [SEL_W]  external select (MUX_MODE_SEL only)
//   rr_ptr    [SEL_W]  round-robin start index (MUX_MODE_RR only)
//   grant_vld          a grant exists this cycle
//   grant_idx [SEL_W]  granted input index (0 when grant_vld=0)
// -----------------------------------------------------------------------------
module mux_arb_grant
    import mux_pkg::*;
#(
    parameter int M     = 4,
    parameter int MODE  = MUX_MODE_SEL,
    parameter int SEL_W = clog2(M)
) (
    input  logic [M-1:0]     in_valid,
    input  logic [SEL_W-1:0] sel,
    input  logic [SEL_W-1:0] rr_ptr,
    output logic             grant_vld,
    output logic [SEL_W-1:0] grant_idx
);

    int scan_idx;

    // Priority and round-robin loops run from the far end downward so the
    // last assignment to win is the first candidate in scan order.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        if (MODE == MUX_MODE_SEL) begin
            if (int'(sel) < M) begin
                grant_vld = 1'b1;
                grant_idx = sel;
            end
        end else if (MODE == MUX_MODE_PRIO) begin
            for (int i = M - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end else begin
            for (int k = M - 1; k >= 0; k--) begin
                scan_idx = int'(rr_ptr) + k;
                if (scan_idx >= M) begin
                    scan_idx = scan_idx - M;
                end
                if (in_valid[scan_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(scan_idx);
                end
            end
        end
    end

endmodule

// File: rtl/mux_arb_nx1.sv
// -----------------------------------------------------------------------------
// mux_arb_nx1
// M-input, N-bit arbitrating selector with a registered output stage and
// valid/ready handshakes on every input and on the output.
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   flush                kills the output entry, blocks acceptance this cycle
//   in_data  [M*N]       input data, slice i at [i*N +: N]
//   in_valid [M]         per-input request valid
//   in_ready [M]         per-input accept (one-hot or zero)
//   sel      [SEL_W]     external select, used when MODE = MUX_MODE_SEL
//   out_data [N]         registered selected data
//   out_src  [SEL_W]     index of the input that produced out_data
//   out_valid/out_ready  output handshake
// -----------------------------------------------------------------------------
module mux_arb_nx1
    import mux_pkg::*;
#(
    parameter int N     = 32,
    parameter int M     = 4,
    parameter int MODE  = MUX_MODE_SEL,
    parameter int SEL_W = clog2(M)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [M*N-1:0]   in_data,
    input  logic [M-1:0]     in_valid,
    output logic [M-1:0]     in_ready,
    input  logic [SEL_W-1:0] sel,
    output logic [N-1:0]     out_data,
    output logic [SEL_W-1:0] out_src,
    output logic             out_valid,
    input  logic             out_ready
);

    logic             load;
    logic             xfer;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W-1:0] rr_ptr;
    logic [N-1:0]     grant_data;

    mux_arb_grant #(
        .M     (M),
        .MODE  (MODE),
        .SEL_W (SEL_W)
    ) u_grant (
        .in_valid  (in_valid),
        .sel       (sel),
        .rr_ptr    (rr_ptr),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx)
    );

    // The output register may take new data when it is empty or draining.
    assign load = !out_valid || out_ready;

    // Only the granted input sees ready; in external-select mode this does
    // not wait for in_valid, so a requester can rely on ready alone.
    always_comb begin
        in_ready = '0;
        if (load && !flush && !rst && grant_vld) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    assign xfer = |(in_valid & in_ready);

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < M; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_data = in_data[i*N +: N];
            end
        end
    end

    // Output stage: data/src only move on a real transfer, so a bubble or a
    // flush leaves the last payload visible but marked invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (load) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data <= grant_data;
                    out_src  <= grant_idx;
                end
            end
            if ((MODE == MUX_MODE_RR) && xfer) begin
                rr_ptr <= (int'(grant_idx) == M - 1) ? '0 : grant_idx + SEL_W'(1);
            end
        end
    end

endmodule
